// File: rtl/board_ram_writer_if.sv
// Command handshake between game control (master) and one board's RAM writer (slave).
interface board_ram_writer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_cursor;
  logic [2:0] cmd_len;
  logic       cmd_vert;
  logic       done;
  logic [2:0] result;

  modport master (
    output cmd_valid, cmd_op, cmd_cursor, cmd_len, cmd_vert,
    input  cmd_ready, done, result
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cursor, cmd_len, cmd_vert,
    output cmd_ready, done, result
  );
endinterface

// File: rtl/board_ram_writer.sv
// Write-side owner of one player's board RAM: CLEAR / PLACE / FIRE commands.
// Define BOARD_OVERLAP_CHECK_EN to read back ship cells and reject overlapping PLACEs.
module board_ram_writer #(
  parameter int GRID_W  = 10,
  parameter int GRID_H  = 10,
  parameter int MAX_LEN = 5
) (
  input  logic                clk,
  input  logic                rst,
  board_ram_writer_if.slave   cmd,
  output logic [9:0]          ram_addr,
  output logic                ram_we,
  output logic [1:0]          ram_wdata,
  input  logic [1:0]          ram_rd_data,
  output logic [4:0]          cells_left,
  output logic                all_sunk
);

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_PLACE = 2'd1;
  localparam logic [1:0] OP_FIRE  = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [1:0] TILE_EMPTY = 2'd0;
  localparam logic [1:0] TILE_HIT   = 2'd1;
  localparam logic [1:0] TILE_MISS  = 2'd2;
  localparam logic [1:0] TILE_SHIP  = 2'd3;

  localparam logic [2:0] RES_OK     = 3'd0;
  localparam logic [2:0] RES_REJECT = 3'd1;
  localparam logic [2:0] RES_HIT    = 3'd2;
  localparam logic [2:0] RES_MISS   = 3'd3;
  localparam logic [2:0] RES_REPEAT = 3'd4;

  localparam logic [4:0] W_LIM   = 5'(GRID_W);
  localparam logic [4:0] H_LIM   = 5'(GRID_H);
  localparam logic [4:0] X_LAST  = 5'(GRID_W - 1);
  localparam logic [4:0] Y_LAST  = 5'(GRID_H - 1);
  localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE, CLR, CHK_ISSUE, CHK_DRAIN, PLC_WR, FIRE_WAIT, FIRE_EVAL, FIN
  } state_t;

  state_t     state, state_d;
  logic [9:0] addr_d;
  logic       we_d;
  logic [1:0] wdata_d;
  logic       done_q, done_d;
  logic [2:0] result_q, result_d;
  logic [4:0] cells_d;
  logic       armed, armed_d;
  logic       all_sunk_d;
  logic [2:0] len_q, len_d;
  logic       vert_q, vert_d;
  logic [2:0] cnt, cnt_d;
`ifdef BOARD_OVERLAP_CHECK_EN
  logic [9:0] org_q, org_d;
  logic       issue_v, issue_d;
  logic       ret_v, ret_d;
  logic       overlap, overlap_d;
`endif

  // Command decode: 5-bit arithmetic so the ship end never wraps.
  logic [4:0] in_x, in_y, in_len, end_x, end_y;
  logic       xy_bad, len_bad, run_bad, reject_in;
  logic [5:0] cells_sum;

  assign in_x      = {1'b0, cmd.cmd_cursor[7:4]};
  assign in_y      = {1'b0, cmd.cmd_cursor[3:0]};
  assign in_len    = {2'b00, cmd.cmd_len};
  assign end_x     = in_x + in_len - 5'd1;
  assign end_y     = in_y + in_len - 5'd1;
  assign xy_bad    = (in_x >= W_LIM) || (in_y >= H_LIM);
  assign len_bad   = (in_len < 5'd2) || (in_len > LEN_MAX);
  assign run_bad   = cmd.cmd_vert ? (end_y >= H_LIM) : (end_x >= W_LIM);
  assign reject_in = (cmd.cmd_op == OP_RSVD) ||
                     ((cmd.cmd_op == OP_PLACE) && (xy_bad || len_bad || run_bad)) ||
                     ((cmd.cmd_op == OP_FIRE) && xy_bad);
  assign cells_sum = {1'b0, cells_left} + {3'b000, len_q};

  assign cmd.cmd_ready = (state == IDLE);
  assign cmd.done      = done_q;
  assign cmd.result    = result_q;

  function automatic logic [9:0] step(input logic [9:0] a, input logic v);
    return v ? a + 10'd32 : a + 10'd1;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d  = state;
    addr_d   = ram_addr;
    we_d     = 1'b0;
    wdata_d  = ram_wdata;
    done_d   = 1'b0;
    result_d = result_q;
    cells_d  = cells_left;
    armed_d  = armed;
    len_d    = len_q;
    vert_d   = vert_q;
    cnt_d    = cnt;
`ifdef BOARD_OVERLAP_CHECK_EN
    org_d     = org_q;
    issue_d   = 1'b0;
    ret_d     = issue_v;
    overlap_d = overlap | (ret_v && (ram_rd_data != TILE_EMPTY));
`endif

    unique case (state)
      IDLE: begin
        if (cmd.cmd_valid) begin
          len_d  = cmd.cmd_len;
          vert_d = cmd.cmd_vert;
          cnt_d  = cmd.cmd_len - 3'd1;
          if (reject_in) begin
            done_d   = 1'b1;
            result_d = RES_REJECT;
          end else begin
            unique case (cmd.cmd_op)
              OP_CLEAR: begin
                state_d = CLR;
                addr_d  = '0;
                we_d    = 1'b1;
                wdata_d = TILE_EMPTY;
              end
              OP_PLACE: begin
                addr_d = {in_y, in_x};
`ifdef BOARD_OVERLAP_CHECK_EN
                state_d   = CHK_ISSUE;
                org_d     = {in_y, in_x};
                issue_d   = 1'b1;
                overlap_d = 1'b0;
`else
                state_d = PLC_WR;
                we_d    = 1'b1;
                wdata_d = TILE_SHIP;
`endif
              end
              default: begin
                state_d = FIRE_WAIT;
                addr_d  = {in_y, in_x};
              end
            endcase
          end
        end
      end

      // Row-major sweep; columns at or beyond GRID_W are skipped.
      CLR: begin
        if (ram_addr[4:0] == X_LAST) begin
          if (ram_addr[9:5] == Y_LAST) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            result_d = RES_OK;
            cells_d  = '0;
            armed_d  = 1'b0;
          end else begin
            addr_d = {ram_addr[9:5] + 5'd1, 5'd0};
            we_d   = 1'b1;
          end
        end else begin
          addr_d = ram_addr + 10'd1;
          we_d   = 1'b1;
        end
      end

`ifdef BOARD_OVERLAP_CHECK_EN
      CHK_ISSUE: begin
        if (cnt == 3'd0) begin
          state_d = CHK_DRAIN;
        end else begin
          addr_d  = step(ram_addr, vert_q);
          cnt_d   = cnt - 3'd1;
          issue_d = 1'b1;
        end
      end

      // Wait until the last read has returned and been folded into overlap.
      CHK_DRAIN: begin
        if (!ret_v) begin
          if (overlap) begin
            state_d = FIN;
          end else begin
            state_d = PLC_WR;
            addr_d  = org_q;
            we_d    = 1'b1;
            wdata_d = TILE_SHIP;
            cnt_d   = len_q - 3'd1;
          end
        end
      end
`endif

      PLC_WR: begin
        if (cnt == 3'd0) begin
          state_d = FIN;
        end else begin
          addr_d = step(ram_addr, vert_q);
          cnt_d  = cnt - 3'd1;
          we_d   = 1'b1;
        end
      end

      FIRE_WAIT: state_d = FIRE_EVAL;

      FIRE_EVAL: begin
        state_d = IDLE;
        done_d  = 1'b1;
        unique case (ram_rd_data)
          TILE_EMPTY: begin
            we_d     = 1'b1;
            wdata_d  = TILE_MISS;
            result_d = RES_MISS;
          end
          TILE_SHIP: begin
            we_d     = 1'b1;
            wdata_d  = TILE_HIT;
            result_d = RES_HIT;
            cells_d  = (cells_left == '0) ? '0 : cells_left - 5'd1;
          end
          default: result_d = RES_REPEAT;
        endcase
      end

      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
`ifdef BOARD_OVERLAP_CHECK_EN
        if (overlap) begin
          result_d = RES_REJECT;
        end else begin
          result_d = RES_OK;
          cells_d  = cells_sum[5] ? 5'd31 : cells_sum[4:0];
          armed_d  = 1'b1;
        end
`else
        result_d = RES_OK;
        cells_d  = cells_sum[5] ? 5'd31 : cells_sum[4:0];
        armed_d  = 1'b1;
`endif
      end

      default: state_d = IDLE;
    endcase

    all_sunk_d = done_d ? (armed_d && (cells_d == '0)) : all_sunk;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register samples pre-edge values together.
    if (rst) begin
      state      <= IDLE;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= TILE_EMPTY;
      done_q     <= 1'b0;
      result_q   <= RES_OK;
      cells_left <= '0;
      armed      <= 1'b0;
      all_sunk   <= 1'b0;
      len_q      <= '0;
      vert_q     <= 1'b0;
      cnt        <= '0;
`ifdef BOARD_OVERLAP_CHECK_EN
      org_q      <= '0;
      issue_v    <= 1'b0;
      ret_v      <= 1'b0;
      overlap    <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      ram_addr   <= addr_d;
      ram_we     <= we_d;
      ram_wdata  <= wdata_d;
      done_q     <= done_d;
      result_q   <= result_d;
      cells_left <= cells_d;
      armed      <= armed_d;
      all_sunk   <= all_sunk_d;
      len_q      <= len_d;
      vert_q     <= vert_d;
      cnt        <= cnt_d;
`ifdef BOARD_OVERLAP_CHECK_EN
      org_q      <= org_d;
      issue_v    <= issue_d;
      ret_v      <= ret_d;
      overlap    <= overlap_d;
`endif
    end
  end

endmodule
